pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage RV32 core (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the 5-stage RV32 pipeline and its hazard /
//                redirect sequencer. The pipeline side (master) supplies the
//                stage register indices and write enables. The sequencer side
//                (slave) returns stall, flush and forwarding controls together
//                with its performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // ID-stage source operands
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    // In-flight destinations
    logic [4:0]       ex_rd_i;
    logic             ex_rf_we_i;
    logic             ex_is_load_i;
    logic [4:0]       mem_rd_i;
    logic             mem_rf_we_i;
    logic [4:0]       wb_rd_i;
    logic             wb_rf_we_i;
    // Control-flow redirect resolved in EX
    logic             ex_redirect_i;
    // Sequencer controls
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic [1:0]       fwd_a_sel_o;
    logic [1:0]       fwd_b_sel_o;
    // Performance counters
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_rf_we_i, ex_is_load_i,
        output mem_rd_i, mem_rf_we_i, wb_rd_i, wb_rf_we_i,
        output ex_redirect_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
        input  fwd_a_sel_o, fwd_b_sel_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_rf_we_i, ex_is_load_i,
        input  mem_rd_i, mem_rf_we_i, wb_rd_i, wb_rf_we_i,
        input  ex_redirect_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
        output fwd_a_sel_o, fwd_b_sel_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central sequencer for the IF/ID/EX/MEM/WB RV32 pipeline.
//                Detects RAW hazards between the ID sources and in-flight
//                destinations, stalls PC/IF_ID, flushes IF_ID/ID_EX on EX
//                redirects (RUN/FLUSH state machine), optionally drives the
//                operand forwarding selects, and keeps saturating stall/flush
//                performance counters.
//  Options     : FORWARD_EN (macro) - enables operand forwarding; only a
//                load-use dependency then stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYC = 1,   // IF_ID squash length after a redirect (1..3)
    parameter int RF_BYPASS = 1,   // 1: write-first RF hides the WB-stage match
    parameter int CNT_W     = 32   // performance counter width
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]       S_RUN          = 1'b0;
    localparam logic [0:0]       S_FLUSH        = 1'b1;
    localparam logic [1:0]       C_FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
    localparam logic             C_MULTI_FLUSH  = (FLUSH_CYC > 1);
    localparam logic             C_WB_VISIBLE   = (RF_BYPASS == 0);
    localparam logic [CNT_W-1:0] C_CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0]       C_FWD_RF       = 2'd0;
    localparam logic [1:0]       C_FWD_MEM      = 2'd1;
    localparam logic [1:0]       C_FWD_WB       = 2'd2;

    // A read of a written register; x0 is hard-wired and never conflicts.
    function automatic logic f_match(
        input logic [4:0] rs,
        input logic       rs_used,
        input logic [4:0] rd,
        input logic       we
    );
        return we && (rd != 5'd0) && (rs == rd) && rs_used;
    endfunction

    // ------------------------------------------------------------------
    // Per-stage source/destination matches
    // ------------------------------------------------------------------
    logic w_rs1_ex;
    logic w_rs2_ex;
    logic w_rs1_mem;
    logic w_rs2_mem;
    logic w_rs1_wb;
    logic w_rs2_wb;

    assign w_rs1_ex  = f_match(hz.id_rs1_i, hz.id_rs1_used_i, hz.ex_rd_i,  hz.ex_rf_we_i);
    assign w_rs2_ex  = f_match(hz.id_rs2_i, hz.id_rs2_used_i, hz.ex_rd_i,  hz.ex_rf_we_i);
    assign w_rs1_mem = f_match(hz.id_rs1_i, hz.id_rs1_used_i, hz.mem_rd_i, hz.mem_rf_we_i);
    assign w_rs2_mem = f_match(hz.id_rs2_i, hz.id_rs2_used_i, hz.mem_rd_i, hz.mem_rf_we_i);
    assign w_rs1_wb  = f_match(hz.id_rs1_i, hz.id_rs1_used_i, hz.wb_rd_i,  hz.wb_rf_we_i);
    assign w_rs2_wb  = f_match(hz.id_rs2_i, hz.id_rs2_used_i, hz.wb_rd_i,  hz.wb_rf_we_i);

    logic       w_hazard;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

`ifdef FORWARD_EN
    // Results from MEM and WB can be bypassed; only a load in EX has no
    // value yet, so that is the single case that must stall for one cycle.
    assign w_hazard = hz.ex_is_load_i && (w_rs1_ex || w_rs2_ex);

    // Operand source select; the younger MEM result wins over WB.
    always_comb begin
        w_fwd_a = C_FWD_RF;
        w_fwd_b = C_FWD_RF;
        if (w_rs1_mem) begin
            w_fwd_a = C_FWD_MEM;
        end else if (w_rs1_wb && C_WB_VISIBLE) begin
            w_fwd_a = C_FWD_WB;
        end
        if (w_rs2_mem) begin
            w_fwd_b = C_FWD_MEM;
        end else if (w_rs2_wb && C_WB_VISIBLE) begin
            w_fwd_b = C_FWD_WB;
        end
    end
`else
    // Without bypass paths every in-flight writer of a source must drain.
    // A write-first RF makes the WB-stage writer visible to ID already.
    assign w_hazard = w_rs1_ex  || w_rs2_ex  ||
                      w_rs1_mem || w_rs2_mem ||
                      (C_WB_VISIBLE && (w_rs1_wb || w_rs2_wb));
    assign w_fwd_a  = C_FWD_RF;
    assign w_fwd_b  = C_FWD_RF;

    // The load flag only matters when forwarding is available.
    logic w_unused_load;
    assign w_unused_load = hz.ex_is_load_i;
`endif

    // ------------------------------------------------------------------
    // Redirect / stall state machine
    // ------------------------------------------------------------------
    logic [0:0] r_state_q;
    logic [0:0] w_state_d;
    logic [1:0] r_flush_left_q;
    logic [1:0] w_flush_left_d;

    logic       w_pc_stall;
    logic       w_ifid_stall;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_redirect_acc;

    // Next-state and same-cycle control decode; redirect outranks any stall.
    always_comb begin
        w_state_d      = r_state_q;
        w_flush_left_d = r_flush_left_q;
        w_pc_stall     = 1'b0;
        w_ifid_stall   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_redirect_acc = 1'b0;

        case (r_state_q)
            S_RUN: begin
                if (hz.ex_redirect_i) begin
                    w_redirect_acc = 1'b1;
                    w_ifid_flush   = 1'b1;
                    w_idex_flush   = 1'b1;
                    if (C_MULTI_FLUSH) begin
                        w_state_d      = S_FLUSH;
                        w_flush_left_d = C_FLUSH_RELOAD;
                    end
                end else if (w_hazard) begin
                    // Hold PC and IF_ID, insert a bubble into ID_EX.
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end

            S_FLUSH: begin
                // IF_ID still holds wrong-path fetches; their hazards are moot.
                w_ifid_flush = 1'b1;
                if (hz.ex_redirect_i) begin
                    w_redirect_acc = 1'b1;
                    w_idex_flush   = 1'b1;
                    w_flush_left_d = C_FLUSH_RELOAD;
                end else if (r_flush_left_q <= 2'd1) begin
                    w_state_d      = S_RUN;
                    w_flush_left_d = 2'd0;
                end else begin
                    w_flush_left_d = r_flush_left_q - 2'd1;
                end
            end

            default: begin
                w_state_d      = S_RUN;
                w_flush_left_d = 2'd0;
            end
        endcase
    end

    // State and flush countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= S_RUN;
            r_flush_left_q <= 2'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_flush_left_q <= w_flush_left_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] r_flush_cnt_q;

    // Count stalled cycles and accepted redirects, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt_q <= {CNT_W{1'b0}};
            r_flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (w_pc_stall && (r_stall_cnt_q != C_CNT_MAX)) begin
                r_stall_cnt_q <= r_stall_cnt_q + C_CNT_ONE;
            end
            if (w_redirect_acc && (r_flush_cnt_q != C_CNT_MAX)) begin
                r_flush_cnt_q <= r_flush_cnt_q + C_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hz.pc_stall_o   = w_pc_stall;
    assign hz.ifid_stall_o = w_ifid_stall;
    assign hz.ifid_flush_o = w_ifid_flush;
    assign hz.idex_flush_o = w_idex_flush;
    assign hz.fwd_a_sel_o  = w_fwd_a;
    assign hz.fwd_b_sel_o  = w_fwd_b;
    assign hz.stall_cnt_o  = r_stall_cnt_q;
    assign hz.flush_cnt_o  = r_flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed bench for pipe_hazard_ctrl (FLUSH_CYC=2,
//                RF_BYPASS=0, CNT_W=4). A driver applies one vector per cycle
//                and queues the hand-derived response; a monitor pops and
//                compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_REDIR = 4'b0011;
    localparam logic [3:0] C_SQUASH = 4'b0010;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(
        .FLUSH_CYC (2),
        .RF_BYPASS (0),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [3:0]       ctl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    // Apply one vector after the rising edge and queue its expected response.
    task automatic vec(
        input string      nm,
        input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2,
        input logic [4:0] exrd, input logic exwe, input logic exld,
        input logic [4:0] mrd,  input logic mwe,
        input logic [4:0] wrd,  input logic wwe,
        input logic       redir, input logic r,
        input logic [3:0] ectl, input logic [1:0] efa, input logic [1:0] efb
    );
        exp_t e;
        @(posedge clk);
        #1;
        hz.id_rs1_i      = rs1;
        hz.id_rs1_used_i = u1;
        hz.id_rs2_i      = rs2;
        hz.id_rs2_used_i = u2;
        hz.ex_rd_i       = exrd;
        hz.ex_rf_we_i    = exwe;
        hz.ex_is_load_i  = exld;
        hz.mem_rd_i      = mrd;
        hz.mem_rf_we_i   = mwe;
        hz.wb_rd_i       = wrd;
        hz.wb_rf_we_i    = wwe;
        hz.ex_redirect_i = redir;
        rst              = r;
        if (r) begin
            m_stall = '0;
            m_flush = '0;
        end
        e.nm  = nm;
        e.ctl = ectl;
        e.fa  = efa;
        e.fb  = efb;
        e.sc  = m_stall;
        e.fc  = m_flush;
        q_exp.push_back(e);
        if (!r) begin
            if (ectl[3] && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (redir && (m_flush != '1))   m_flush = m_flush + 1'b1;
        end
    endtask

    task automatic idle(input string nm, input logic r, input logic [3:0] ectl);
        vec(nm, 5'd0,1'b0, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0,
            1'b0, r, ectl, 2'd0, 2'd0);
    endtask

    // Monitor: every presented cycle is checked against the queue head.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            logic [3:0] actl;
            e    = q_exp.pop_front();
            actl = {hz.pc_stall_o, hz.ifid_stall_o, hz.ifid_flush_o, hz.idex_flush_o};
            n_checks++;
            if (actl !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl: got %b expected %b", e.nm, actl, e.ctl);
            end
            n_checks++;
            if ({hz.fwd_a_sel_o, hz.fwd_b_sel_o} !== {e.fa, e.fb}) begin
                n_fail++;
                $display("FAIL %s fwd: got a=%0d b=%0d expected a=%0d b=%0d",
                         e.nm, hz.fwd_a_sel_o, hz.fwd_b_sel_o, e.fa, e.fb);
            end
            n_checks++;
            if (hz.stall_cnt_o !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, hz.stall_cnt_o, e.sc);
            end
            n_checks++;
            if (hz.flush_cnt_o !== e.fc) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.nm, hz.flush_cnt_o, e.fc);
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0;
        hz.id_rs1_i = '0; hz.id_rs1_used_i = 1'b0;
        hz.id_rs2_i = '0; hz.id_rs2_used_i = 1'b0;
        hz.ex_rd_i = '0; hz.ex_rf_we_i = 1'b0; hz.ex_is_load_i = 1'b0;
        hz.mem_rd_i = '0; hz.mem_rf_we_i = 1'b0;
        hz.wb_rd_i = '0; hz.wb_rf_we_i = 1'b0;
        hz.ex_redirect_i = 1'b0;
        #2 rst = 1'b1;

        // Reset state
        idle("reset", 1'b1, C_IDLE);
        idle("run_idle", 1'b0, C_IDLE);

        // EX -> MEM -> WB dependency chain on rs1=x5
        vec("t1_ex",  5'd5,1'b1, 5'd0,1'b0, 5'd5,1'b1,1'b0, 5'd0,1'b0, 5'd0,1'b0, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, 2'd0, 2'd0);
        vec("t1_mem", 5'd5,1'b1, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd5,1'b1, 5'd0,1'b0, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, FWD ? 2'd1 : 2'd0, 2'd0);
        vec("t1_wb",  5'd5,1'b1, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd5,1'b1, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, FWD ? 2'd2 : 2'd0, 2'd0);
        vec("t1_clear", 5'd5,1'b1, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 1'b0,1'b0,
            C_IDLE, 2'd0, 2'd0);

        // x0 never conflicts, in any stage
        vec("t2_x0",  5'd0,1'b1, 5'd0,1'b1, 5'd0,1'b1,1'b1, 5'd0,1'b1, 5'd0,1'b1, 1'b0,1'b0,
            C_IDLE, 2'd0, 2'd0);
        // Unused source does not conflict
        vec("unused_rs", 5'd9,1'b0, 5'd9,1'b0, 5'd9,1'b1,1'b1, 5'd9,1'b1, 5'd9,1'b1, 1'b0,1'b0,
            C_IDLE, 2'd0, 2'd0);

        // Load-use on rs2=x7, then the load result sits in MEM
        vec("t3_load", 5'd0,1'b0, 5'd7,1'b1, 5'd7,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 1'b0,1'b0,
            C_STALL, 2'd0, 2'd0);
        vec("t3_mem",  5'd0,1'b0, 5'd7,1'b1, 5'd0,1'b0,1'b0, 5'd7,1'b1, 5'd0,1'b0, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, 2'd0, FWD ? 2'd1 : 2'd0);

        // MEM and WB both write x3: younger MEM wins
        vec("t4_memwb", 5'd3,1'b1, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd3,1'b1, 5'd3,1'b1, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, FWD ? 2'd1 : 2'd0, 2'd0);
        // rs2 matches WB only (RF is not write-first here)
        vec("wb_rs2", 5'd0,1'b0, 5'd4,1'b1, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd4,1'b1, 1'b0,1'b0,
            FWD ? C_IDLE : C_STALL, 2'd0, FWD ? 2'd2 : 2'd0);

        // Redirect with a concurrent load-use hazard: flush only
        vec("t5_redir", 5'd5,1'b1, 5'd0,1'b0, 5'd5,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 1'b1,1'b0,
            C_REDIR, 2'd0, 2'd0);
        vec("t5_flush", 5'd6,1'b1, 5'd0,1'b0, 5'd6,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 1'b0,1'b0,
            C_SQUASH, 2'd0, 2'd0);
        idle("t5_back", 1'b0, C_IDLE);

        // Redirect again while in FLUSH reloads the squash window
        vec("rr_first", 5'd0,1'b0, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 1'b1,1'b0,
            C_REDIR, 2'd0, 2'd0);
        vec("rr_second", 5'd0,1'b0, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 1'b1,1'b0,
            C_REDIR, 2'd0, 2'd0);
        idle("rr_tail", 1'b0, C_SQUASH);
        idle("rr_run", 1'b0, C_IDLE);

        // Reset in the middle of FLUSH
        vec("t6_redir", 5'd0,1'b0, 5'd0,1'b0, 5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 1'b1,1'b0,
            C_REDIR, 2'd0, 2'd0);
        idle("t6_rst", 1'b1, C_IDLE);
        idle("t6_after", 1'b0, C_IDLE);

        // Held load-use stall drives stall_cnt into saturation
        for (int i = 0; i < 20; i++) begin
            vec("sat_hold", 5'd8,1'b1, 5'd0,1'b0, 5'd8,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 1'b0,1'b0,
                C_STALL, 2'd0, 2'd0);
        end
        idle("sat_end", 1'b0, C_IDLE);

        // Drain the scoreboard within a bounded number of cycles
        budget = 0;
        while ((q_exp.size() > 0) && (budget < 10)) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (q_exp.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
